// File: rtl/vae_pkg.sv
// Shared definitions for the 3x3 window generator:
// default pixel width, default image geometry and the frame FSM states.
package vae_pkg;

    localparam int DW_DEF    = 16;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: a DEPTH-deep shift register.
// It advances only when en_i is high.
module line_buffer #(
    parameter int DW    = 16,
    parameter int DEPTH = 28
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents are never reset; the window logic never exposes stale rows.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/window3x3_gen.sv
// Streams a raster frame and emits every fully-populated 3x3 window.
// d1..d9 are registered copies of the window, updated only when emitted.
module window3x3_gen
    import vae_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] d1,
    output logic [DW-1:0] d2,
    output logic [DW-1:0] d3,
    output logic [DW-1:0] d4,
    output logic [DW-1:0] d5,
    output logic [DW-1:0] d6,
    output logic [DW-1:0] d7,
    output logic [DW-1:0] d8,
    output logic [DW-1:0] d9,
    output logic          out_valid,
    output logic          frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          done_q;
    logic [DW-1:0] win_q  [9];
    logic [DW-1:0] win_d  [9];
    logic [DW-1:0] dout_q [9];
    logic [DW-1:0] l1_out;
    logic [DW-1:0] l2_out;

    logic accept;
    logic last_col;
    logic last_row;
    logic emit;

    assign accept   = in_valid && in_ready_q;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));
    assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_line1 (
        .clk    (clk),
        .en_i   (accept),
        .din_i  (in_data),
        .dout_o (l1_out)
    );

    line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_line2 (
        .clk    (clk),
        .en_i   (accept),
        .din_i  (l1_out),
        .dout_o (l2_out)
    );

    // Shift the window left one column; new column is {row r-2, r-1, r}.
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
        end
        win_d[2] = l2_out;
        win_d[5] = l1_out;
        win_d[8] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        in_ready_q <= 1'b1;
                        col_q      <= '0;
                        row_q      <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        win_q <= win_d;
                        if (emit) begin
                            dout_q      <= win_d;
                            out_valid_q <= 1'b1;
                        end
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (last_col && last_row) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign frame_done = done_q;
    assign d1 = dout_q[0];
    assign d2 = dout_q[1];
    assign d3 = dout_q[2];
    assign d4 = dout_q[3];
    assign d5 = dout_q[4];
    assign d6 = dout_q[5];
    assign d7 = dout_q[6];
    assign d8 = dout_q[7];
    assign d9 = dout_q[8];

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: 4x4 vector table, reset/back-to-back sequences,
// and a 28x28 random frame checked against an image-based reference.
module tb_window3x3_gen;

    typedef logic [8:0][15:0] win_t;

    typedef struct {
        win_t w;
        int   due;
    } exp_t;

    typedef struct {
        int   base;
        int   stall_after;
        int   stall_len;
        int   glitch_at;
        win_t first;
        win_t last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0;
    logic        start28 = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;

    logic in_ready4, out_valid4, done4;
    logic in_ready28, out_valid28, done28;
    win_t d4w, d28w;

    bit   sel = 1'b0;
    int   W = 4;
    int   H = 4;
    logic in_ready_m, ov_m, fd_m;
    win_t d_m;

    exp_t wq[$];
    int   dq[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   win_cnt = 0;
    int   done_cnt = 0;
    win_t first_w = '0;
    win_t last_w = '0;
    win_t hold_w = '0;
    int   img[784];
    vec_t vec[4];

    exp_t e;
    bit   ev, ed;

    always #5 clk = ~clk;

    window3x3_gen #(.DW(16), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
        .d1(d4w[0]), .d2(d4w[1]), .d3(d4w[2]),
        .d4(d4w[3]), .d5(d4w[4]), .d6(d4w[5]),
        .d7(d4w[6]), .d8(d4w[7]), .d9(d4w[8]),
        .out_valid(out_valid4), .frame_done(done4)
    );

    window3x3_gen #(.DW(16), .IMG_W(28), .IMG_H(28)) dut28 (
        .clk(clk), .rst(rst), .start(start28),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready28),
        .d1(d28w[0]), .d2(d28w[1]), .d3(d28w[2]),
        .d4(d28w[3]), .d5(d28w[4]), .d6(d28w[5]),
        .d7(d28w[6]), .d8(d28w[7]), .d9(d28w[8]),
        .out_valid(out_valid28), .frame_done(done28)
    );

    always_comb begin
        in_ready_m = sel ? in_ready28 : in_ready4;
        ov_m       = sel ? out_valid28 : out_valid4;
        fd_m       = sel ? done28 : done4;
        d_m        = sel ? d28w : d4w;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic win_t pk(input int a[9]);
        win_t r;
        for (int k = 0; k < 9; k++) r[k] = a[k][15:0];
        return r;
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chkw(input string nm, input win_t got, input win_t exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_in_ready"}, in_ready_m, 0);
        chk({nm, "_out_valid"}, ov_m, 0);
        chk({nm, "_frame_done"}, fd_m, 0);
        chkw({nm, "_d"}, d_m, '0);
    endtask

    // Scoreboard: windows and frame_done are due in a specific cycle.
    always @(negedge clk) begin
        if (!rst) begin
            while (wq.size() > 0 && wq[0].due < cyc) begin
                checks++;
                fails++;
                $display("FAIL window_missing: due %0d now %0d", wq[0].due, cyc);
                void'(wq.pop_front());
            end
            while (dq.size() > 0 && dq[0] < cyc) begin
                checks++;
                fails++;
                $display("FAIL done_missing: due %0d now %0d", dq[0], cyc);
                void'(dq.pop_front());
            end
            ev = wq.size() > 0 && wq[0].due == cyc;
            checks++;
            if (ov_m !== ev) begin
                fails++;
                $display("FAIL out_valid: cycle %0d got %0b expected %0b", cyc, ov_m, ev);
            end
            if (ev) begin
                e = wq.pop_front();
                if (ov_m) begin
                    checks++;
                    if (d_m !== e.w) begin
                        fails++;
                        $display("FAIL window: cycle %0d got %h expected %h", cyc, d_m, e.w);
                    end
                    if (win_cnt == 0) first_w = d_m;
                    last_w = d_m;
                    win_cnt++;
                end
                hold_w = e.w;
            end else begin
                checks++;
                if (d_m !== hold_w) begin
                    fails++;
                    $display("FAIL hold: cycle %0d got %h expected %h", cyc, d_m, hold_w);
                end
            end
            ed = dq.size() > 0 && dq[0] == cyc;
            if (ed) void'(dq.pop_front());
            checks++;
            if (fd_m !== ed) begin
                fails++;
                $display("FAIL frame_done: cycle %0d got %0b expected %0b", cyc, fd_m, ed);
            end
            if (fd_m) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        if (sel) start28 = 1'b1;
        else start4 = 1'b1;
        tick();
        start4 = 1'b0;
        start28 = 1'b0;
        chk("ready_after_start", in_ready_m, 1);
    endtask

    task automatic push_pixel(input int r, input int c, input logic [15:0] v);
        int   n;
        win_t w;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready_m && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", in_ready_m, 1);
        img[r*W+c] = v;
        if (r >= 2 && c >= 2) begin
            for (int k = 0; k < 9; k++)
                w[k] = img[(r-2+k/3)*W + (c-2+k%3)][15:0];
            wq.push_back('{w: w, due: cyc + 1});
        end
        if (r == H-1 && c == W-1) dq.push_back(cyc + 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int base, input int stall_after,
                             input int stall_len, input int glitch_at,
                             input bit rnd);
        logic [15:0] v;
        do_start();
        for (int i = 0; i < W*H; i++) begin
            v = rnd ? 16'($urandom_range(0, 65535)) : 16'(base + i);
            if (i == glitch_at) begin
                if (sel) start28 = 1'b1;
                else start4 = 1'b1;
            end
            push_pixel(i / W, i % W, v);
            start4 = 1'b0;
            start28 = 1'b0;
            if (i == stall_after) repeat (stall_len) tick();
        end
    endtask

    task automatic drain();
        repeat (4) tick();
        chk("queue_empty", wq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{0, -1, 0, -1,
                   pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}),
                   pk('{5, 6, 7, 9, 10, 11, 13, 14, 15})};
        vec[1] = '{0, 9, 3, -1,
                   pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}),
                   pk('{5, 6, 7, 9, 10, 11, 13, 14, 15})};
        vec[2] = '{0, -1, 0, 6,
                   pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}),
                   pk('{5, 6, 7, 9, 10, 11, 13, 14, 15})};
        vec[3] = '{100, -1, 0, -1,
                   pk('{100, 101, 102, 104, 105, 106, 108, 109, 110}),
                   pk('{105, 106, 107, 109, 110, 111, 113, 114, 115})};

        sel = 1'b0;
        W = 4;
        H = 4;
        tick();
        tick();
        chk_zero("reset_state");
        rst = 1'b0;
        tick();

        for (int t = 0; t < 4; t++) begin
            win_cnt = 0;
            done_cnt = 0;
            run_frame(vec[t].base, vec[t].stall_after, vec[t].stall_len,
                      vec[t].glitch_at, 1'b0);
            drain();
            chk($sformatf("v%0d_windows", t), win_cnt, 4);
            chk($sformatf("v%0d_done", t), done_cnt, 1);
            chkw($sformatf("v%0d_first", t), first_w, vec[t].first);
            chkw($sformatf("v%0d_last", t), last_w, vec[t].last);
        end

        // Reset in the middle of a frame, then a fresh frame.
        done_cnt = 0;
        do_start();
        for (int i = 0; i < 12; i++) push_pixel(i / 4, i % 4, 16'(i));
        rst = 1'b1;
        #1;
        chk_zero("mid_reset");
        wq.delete();
        dq.delete();
        hold_w = '0;
        tick();
        rst = 1'b0;
        tick();
        win_cnt = 0;
        run_frame(100, -1, 0, -1, 1'b0);
        drain();
        chk("rst_windows", win_cnt, 4);
        chk("rst_done", done_cnt, 1);
        chkw("rst_first", first_w,
             pk('{100, 101, 102, 104, 105, 106, 108, 109, 110}));

        // Back-to-back frames: start in the IDLE cycle after DONE.
        win_cnt = 0;
        done_cnt = 0;
        run_frame(0, -1, 0, -1, 1'b0);
        tick();
        run_frame(200, -1, 0, -1, 1'b0);
        drain();
        chk("b2b_windows", win_cnt, 8);
        chk("b2b_done", done_cnt, 2);
        chkw("b2b_last", last_w,
             pk('{205, 206, 207, 209, 210, 211, 213, 214, 215}));

        // Full-size random frame.
        sel = 1'b1;
        W = 28;
        H = 28;
        hold_w = '0;
        tick();
        win_cnt = 0;
        done_cnt = 0;
        run_frame(0, -1, 0, -1, 1'b1);
        drain();
        chk("big_windows", win_cnt, 676);
        chk("big_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/window3x3_gen.md
WINDOW3X3_GEN -- requirements
Module: window3x3_gen

Interface
REQ-001 Parameter DW, default 16: pixel width, Q-format fixed point, passed through unmodified.
REQ-002 Parameter IMG_W, default 28: image width in pixels, legal range 3..1024.
REQ-003 Parameter IMG_H, default 28: image height in pixels, legal range 3..1024.
REQ-004 clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  one-cycle pulse that begins a frame.
REQ-007 in_valid  in  1  in_data holds a valid pixel this cycle.
REQ-008 in_data  in  DW  pixel, raster order (row-major, top-left first).
REQ-009 in_ready  out  1  block accepts a pixel this cycle.
REQ-010 d1..d9  out  DW each  3x3 window, row-major: d1..d3 top row, d9 bottom-right (newest pixel).
REQ-011 out_valid  out  1  d1..d9 hold a complete window, one-cycle qualifier.
REQ-012 frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 Transitions:
  - IDLE->RUN on start.
  - RUN->DONE on acceptance of pixel (IMG_H-1, IMG_W-1).
  - DONE->IDLE unconditionally after one cycle.
REQ-015 in_ready SHALL be 1 in RUN only.
REQ-016 A pixel is accepted when in_valid && in_ready; in_data is ignored otherwise.
REQ-017 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance only on acceptance; col wraps to 0 and increments row; both clear on entry to RUN.
REQ-018 Two line buffers of IMG_W entries SHALL hold rows r-1 and r-2; each buffer shifts only on acceptance.
REQ-019 A 3x3 window register SHALL shift left by one column on each acceptance: the new column is {line2 out, line1 out, in_data}.
REQ-020 out_valid SHALL assert in the cycle after accepting pixel (r,c) with r>=2 and c>=2, and SHALL deassert in every other cycle.
REQ-021 Windows per frame SHALL be (IMG_H-2)*(IMG_W-2); there is no padding and no window spans a row wrap.
REQ-022 in_valid low in RUN is a stall: counters, buffers and window hold, and out_valid is 0.
REQ-023 d1..d9 SHALL hold their last values while out_valid is 0.
REQ-024 start in RUN or DONE SHALL be ignored.
REQ-025 frame_done SHALL be 1 exactly in the DONE cycle.
REQ-026 A start in the IDLE cycle following DONE SHALL begin the next frame with no other dead cycles.
REQ-027 Latency: acceptance of pixel (r,c) to the window containing it at d9 is 1 cycle.

Reset
REQ-028 rst asserted SHALL immediately force:
  - state IDLE;
  - row, col, in_ready, out_valid, frame_done = 0;
  - d1..d9 and window registers = 0.
REQ-029 Line-buffer contents need not be reset; they are never visible at d1..d9 before being refilled.
REQ-030 rst mid-frame SHALL abandon the frame: no frame_done is issued, and the next start begins a fresh frame from (0,0).

Structure
REQ-031 Shared package vae_pkg SHALL hold DW, the default IMG_W/IMG_H and the FSM state typedef.
REQ-032 One sub-module, line_buffer (parameters DW and DEPTH, shift-enable, shift-register or RAM implementation), SHALL be instantiated twice.
REQ-033 Outputs d1..d9 SHALL be driven directly from registers, with no combinational path from in_data.

Verification
REQ-034 IMG_W=IMG_H=4, pixels 0..15, in_valid held high:
  - out_valid 4 times;
  - first window d1..d9 = 0,1,2,4,5,6,8,9,10, one cycle after pixel 10;
  - last window = 5,6,7,9,10,11,13,14,15;
  - frame_done one cycle after pixel 15.
REQ-035 Same frame with in_valid low for 3 cycles after pixel 9: identical windows, the first delayed 3 cycles, no out_valid during the stall.
REQ-036 start pulsed mid-frame at pixel 6: ignored; 4 windows and exactly one frame_done.
REQ-037 rst asserted after pixel 11: all outputs 0 immediately; after a new start and pixels 100..115, first window = 100,101,102,104,105,106,108,109,110.
REQ-038 Two back-to-back frames (start in the cycle after frame_done): 8 windows total; no second-frame window contains first-frame pixels.
REQ-039 IMG_W=28, IMG_H=28 random frame: 676 windows, each matching a software 3x3 reference model.
